// File: rtl/mem_bist_master_if.sv
// Memory request bus between a BIST master and the memory under test.
//   valid_o  : request valid (master -> slave)
//   wr_rd_o  : 1 = write, 0 = read
//   addr_o   : word address
//   wdata_o  : write data
//   rdata_i  : read data (slave -> master), sampled together with ready_i
//   ready_i  : request completion handshake (slave -> master)
interface mem_bist_master_if #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = 4
) ();

    logic                  valid_o;
    logic                  wr_rd_o;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [WIDTH-1:0]      wdata_o;
    logic [WIDTH-1:0]      rdata_i;
    logic                  ready_i;

    modport master (
        output valid_o,
        output wr_rd_o,
        output addr_o,
        output wdata_o,
        input  rdata_i,
        input  ready_i
    );

    modport slave (
        input  valid_o,
        input  wr_rd_o,
        input  addr_o,
        input  wdata_o,
        output rdata_i,
        output ready_i
    );

endinterface : mem_bist_master_if

// File: rtl/mem_bist_master.sv
// Memory BIST master: writes seed^addr to every word, reads every word back
// and compares, reporting mismatch count, first failing address and handshake
// timeouts.
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-low reset
//   start_i      : begin a run (honoured in IDLE and FIN only)
//   seed_i       : pattern seed, captured on start
//   mem          : memory request bus (master side)
//   busy_o       : run in progress
//   done_o       : run finished (held until next start)
//   pass_o       : finished with no mismatch and no timeout
//   timeout_o    : a request saw no ready_i within TIMEOUT cycles
//   err_count_o  : read mismatches, saturating at DEPTH
//   fail_addr_o  : address of the first mismatch
module mem_bist_master #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      seed_i,
    mem_bist_master_if.master     mem,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [ADDR_WIDTH:0]   err_count_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o
);

    localparam int unsigned ERR_W  = ADDR_WIDTH + 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ERR_W-1:0]      ERR_MAX   = ERR_W'(DEPTH);
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_GAP = 3'd2,
        RD_REQ = 3'd3,
        RD_GAP = 3'd4,
        FIN    = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Run context
    logic [WIDTH-1:0]      seed_q,    seed_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [WAIT_W-1:0]     wait_q,    wait_d;

    // Registered outputs
    logic                  valid_q,   valid_d;
    logic                  wr_rd_q,   wr_rd_d;
    logic [WIDTH-1:0]      wdata_q,   wdata_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;
    logic                  pass_q,    pass_d;
    logic                  timeout_q, timeout_d;
    logic [ERR_W-1:0]      err_q,     err_d;
    logic [ADDR_WIDTH-1:0] fail_q,    fail_d;

    // Expected memory content for a given word.
    function automatic logic [WIDTH-1:0] pattern(input logic [WIDTH-1:0]      s,
                                                 input logic [ADDR_WIDTH-1:0] a);
        return s ^ WIDTH'(a);
    endfunction

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, FIN: begin
                if (start_i) state_d = WR_REQ;
            end
            WR_REQ: begin
                if (mem.ready_i)              state_d = WR_GAP;
                else if (wait_q == WAIT_LAST) state_d = FIN;
            end
            RD_REQ: begin
                if (mem.ready_i)              state_d = RD_GAP;
                else if (wait_q == WAIT_LAST) state_d = FIN;
            end
            // A ready still high from the previous request must drop first.
            WR_GAP: begin
                if (!mem.ready_i) state_d = (addr_q == LAST_ADDR) ? RD_REQ : WR_REQ;
            end
            RD_GAP: begin
                if (!mem.ready_i) state_d = (addr_q == LAST_ADDR) ? FIN : RD_REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; outputs are decoded from the next
    // state so that the registered copies line up with the state register.
    always_comb begin
        seed_d    = seed_q;
        addr_d    = addr_q;
        wait_d    = wait_q;
        err_d     = err_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;

        unique case (state_q)
            IDLE, FIN: begin
                if (start_i) begin
                    seed_d    = seed_i;
                    addr_d    = '0;
                    wait_d    = '0;
                    err_d     = '0;
                    fail_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            WR_REQ, RD_REQ: begin
                if (mem.ready_i) begin
                    // Read data is valid on the same edge as ready.
                    if (state_q == RD_REQ && mem.rdata_i != pattern(seed_q, addr_q)) begin
                        if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
                        if (err_q == '0)      fail_d = addr_q;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_q == WAIT_LAST) timeout_d = 1'b1;
                end
            end
            WR_GAP: begin
                if (!mem.ready_i) begin
                    wait_d = '0;
                    addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
                end
            end
            RD_GAP: begin
                if (!mem.ready_i) begin
                    wait_d = '0;
                    if (addr_q != LAST_ADDR) addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            default: ;
        endcase

        valid_d = (state_d == WR_REQ) || (state_d == RD_REQ);
        wr_rd_d = (state_d == WR_REQ);
        wdata_d = (state_d == WR_REQ) ? pattern(seed_d, addr_d) : '0;
        busy_d  = (state_d != IDLE) && (state_d != FIN);
        done_d  = (state_d == FIN);
        pass_d  = done_d && (err_d == '0) && !timeout_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            seed_q    <= '0;
            addr_q    <= '0;
            wait_q    <= '0;
            valid_q   <= 1'b0;
            wr_rd_q   <= 1'b0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            fail_q    <= '0;
        end else begin
            seed_q    <= seed_d;
            addr_q    <= addr_d;
            wait_q    <= wait_d;
            valid_q   <= valid_d;
            wr_rd_q   <= wr_rd_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
        end
    end

    assign mem.valid_o  = valid_q;
    assign mem.wr_rd_o  = wr_rd_q;
    assign mem.addr_o   = addr_q;
    assign mem.wdata_o  = wdata_q;

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign timeout_o   = timeout_q;
    assign err_count_o = err_q;
    assign fail_addr_o = fail_q;

endmodule : mem_bist_master
